sprite_write_arbiter: RTL

//  Shares the single write port of the sprite attribute BRAM between two requesters:
//  - host (register-bus writes from the CPU)
//  - motion engine (per-frame position/velocity updates)

---
 rtl/sprite_write_if.sv | 41 ++++
 rtl/sprite_write_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/sprite_write_if.sv
// Write-request bus for the sprite attribute BRAM arbiter: two requester handshakes,
// control strobes and the registered BRAM write port.
interface sprite_write_if #(
    parameter int unsigned FIELD_W = 32
);
    logic               write_window;
    logic               flush;

    logic               host_valid;
    logic               host_ready;
    logic [8:0]         host_index;
    logic [1:0]         host_field;
    logic [FIELD_W-1:0] host_data;

    logic               mot_valid;
    logic               mot_ready;
    logic [8:0]         mot_index;
    logic [1:0]         mot_field;
    logic [FIELD_W-1:0] mot_data;

    logic [8:0]         w_index;
    logic [FIELD_W-1:0] w_data;
    logic [3:0]         w_en;
    logic               busy;

    modport master (
        output write_window, flush,
        output host_valid, host_index, host_field, host_data,
        output mot_valid, mot_index, mot_field, mot_data,
        input  host_ready, mot_ready,
        input  w_index, w_data, w_en, busy
    );

    modport slave (
        input  write_window, flush,
        input  host_valid, host_index, host_field, host_data,
        input  mot_valid, mot_index, mot_field, mot_data,
        output host_ready, mot_ready,
        output w_index, w_data, w_en, busy
    );
endinterface

// File: rtl/sprite_write_arbiter.sv
// Round-robin arbiter sharing the sprite attribute BRAM write port between the host
// register bus and the motion engine, each behind a 1-deep holding register.
module sprite_write_arbiter #(
    parameter int unsigned FIELD_W          = 32,
    parameter bit          HOST_WINDOW_ONLY = 1'b1
) (
    input  logic           clk_draw,
    input  logic           rst_draw_n,
    sprite_write_if.slave  bus
);
    localparam int unsigned IDX_W = 9;
    localparam int unsigned FLD_W = 2;
    localparam int unsigned WEN_W = 4;

    typedef struct packed {
        logic [IDX_W-1:0]   index;
        logic [FLD_W-1:0]   field;
        logic [FIELD_W-1:0] data;
    } req_t;

    req_t               hold_h;
    req_t               hold_m;
    logic               pend_h;
    logic               pend_m;
    logic               last_grant_m;
    logic               host_elig;
    logic               mot_elig;
    logic               same_target;
    logic               gnt_h;
    logic               gnt_m;
    logic               acc_h;
    logic               acc_m;
    logic [IDX_W-1:0]   w_index_q;
    logic [FIELD_W-1:0] w_data_q;
    logic [WEN_W-1:0]   w_en_q;

    // Grant: round-robin on a tie, except a same-target collision where motion goes
    // first so the host value is the one left in the BRAM.
    always_comb begin
        gnt_h       = 1'b0;
        gnt_m       = 1'b0;
        host_elig   = pend_h && (bus.write_window || !HOST_WINDOW_ONLY);
        mot_elig    = pend_m;
        same_target = pend_h && pend_m &&
                      (hold_h.index == hold_m.index) && (hold_h.field == hold_m.field);
        if (host_elig && mot_elig) begin
            if (same_target || !last_grant_m) begin
                gnt_m = 1'b1;
            end else begin
                gnt_h = 1'b1;
            end
        end else if (host_elig) begin
            gnt_h = 1'b1;
        end else if (mot_elig) begin
            gnt_m = 1'b1;
        end
    end

    assign bus.host_ready = !pend_h || gnt_h;
    assign bus.mot_ready  = !pend_m || gnt_m;
    assign acc_h          = bus.host_valid && bus.host_ready;
    assign acc_m          = bus.mot_valid && bus.mot_ready;
    assign bus.busy       = pend_h || pend_m;
    assign bus.w_index    = w_index_q;
    assign bus.w_data     = w_data_q;
    assign bus.w_en       = w_en_q;

    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
        if (!rst_draw_n) begin
            pend_h       <= 1'b0;
            pend_m       <= 1'b0;
            hold_h       <= '0;
            hold_m       <= '0;
            last_grant_m <= 1'b1;
            w_index_q    <= '0;
            w_data_q     <= '0;
            w_en_q       <= '0;
        end else begin
            // Flush wins over a same-cycle accept; the accepted request is discarded.
            if (bus.flush) begin
                pend_h <= 1'b0;
            end else if (acc_h) begin
                pend_h <= 1'b1;
            end else if (gnt_h) begin
                pend_h <= 1'b0;
            end

            if (bus.flush) begin
                pend_m <= 1'b0;
            end else if (acc_m) begin
                pend_m <= 1'b1;
            end else if (gnt_m) begin
                pend_m <= 1'b0;
            end

            if (acc_h) begin
                hold_h <= '{index: bus.host_index, field: bus.host_field, data: bus.host_data};
            end
            if (acc_m) begin
                hold_m <= '{index: bus.mot_index, field: bus.mot_field, data: bus.mot_data};
            end

            if (gnt_h) begin
                w_index_q    <= hold_h.index;
                w_data_q     <= hold_h.data;
                w_en_q       <= WEN_W'(1) << hold_h.field;
                last_grant_m <= 1'b0;
            end else if (gnt_m) begin
                w_index_q    <= hold_m.index;
                w_data_q     <= hold_m.data;
                w_en_q       <= WEN_W'(1) << hold_m.field;
                last_grant_m <= 1'b1;
            end else begin
                w_en_q       <= '0;
            end
        end
    end
endmodule
